instr_fetch_server: RTL and testbench

//  Instruction-side responder for the 16-bit single-cycle MiniMIPS core: accepts a program

---
 rtl/imem_pkg.sv | 23 ++
 rtl/instr_fetch_server_if.sv | 11 +
 rtl/imem_ram.sv | 22 ++
 rtl/instr_fetch_server.sv | 98 +++++++++
 tb/tb_instr_fetch_server.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the MiniMIPS instruction-side server: FSM state
// encodings, the default NOP word and the opcode field position.
package imem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [15:0] NOP_INSTR_DEFAULT = 16'h0000;

  // Opcode field of a MiniMIPS instruction word, shared with the core's controller
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_server_if.sv
// Program-load handshake between the host loader (master) and the
// instruction server (slave).
interface instr_fetch_server_if;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic        load_last;

  modport master (output load_valid, load_data, load_last, input load_ready);
  modport slave  (input load_valid, load_data, load_last, output load_ready);
endinterface

// File: rtl/imem_ram.sv
// 2**AW x 16 instruction store: synchronous write, asynchronous read so a
// fetch completes in the same cycle the core presents its PC.
module imem_ram #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_server.sv
// Instruction-side responder for the MiniMIPS core: loads a program over a
// valid/ready port, then serves instructions for the core PC while gating cpu_run.
// Optional IMEM_FETCH_CNT_EN adds a fetch_count output of executed instructions.
module instr_fetch_server
  import imem_pkg::*;
#(
  parameter int          AW        = 8,
  parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_server_if.slave   ld,
  input  logic                  start,
  input  logic [31:0]           pc,
  output logic [15:0]           instruction,
  output logic                  cpu_run,
  output logic                  halted,
  output logic [AW:0]           prog_len
`ifdef IMEM_FETCH_CNT_EN
  ,
  output logic [31:0]           fetch_count
`endif
);

  localparam logic [AW:0] LEN_MAX = {1'b1, {AW{1'b0}}};

  state_t        state_q, state_d;
  logic [AW-1:0] wptr_q;
  logic [AW:0]   len_q;
  logic          accept;
  logic          last_word;
  logic          in_range;
  logic [15:0]   rdata;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (v >= LEN_MAX) ? LEN_MAX : v + 1'b1;
  endfunction

  assign accept    = ld.load_valid && (state_q == ST_LOAD);
  assign last_word = ld.load_last || (wptr_q == {AW{1'b1}});
  // Full-width compare so a PC beyond the array never aliases onto a low word
  assign in_range  = (pc < 32'(len_q));
  assign prog_len  = len_q;

  imem_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wptr_q),
    .wdata (ld.load_data),
    .raddr (pc[AW-1:0]),
    .rdata (rdata)
  );

  always_comb begin
    state_d       = state_q;
    ld.load_ready = 1'b0;
    cpu_run       = 1'b0;
    halted        = 1'b0;
    instruction   = NOP_INSTR;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        ld.load_ready = 1'b1;
        if (accept && last_word) state_d = ST_READY;
      end
      ST_READY: if (start) state_d = ST_RUN;
      ST_RUN: begin
        cpu_run = 1'b1;
        if (in_range) instruction = rdata;
        else          state_d     = ST_HALT;
      end
      ST_HALT:  halted = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wptr_q  <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        wptr_q <= wptr_q + 1'b1;
        len_q  <= sat_inc(len_q);
      end
    end
  end

`ifdef IMEM_FETCH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)                            fetch_count <= '0;
    else if (state_q == ST_RUN && in_range) fetch_count <= fetch_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch_server.sv
// Scoreboard bench for instr_fetch_server: an AW=8 instance for the main
// flows and an AW=2 instance for the full-array auto-READY case.
module tb_instr_fetch_server;
  localparam logic [15:0] NOP = 16'h0000;

  logic        clk = 1'b0;
  logic        reset, start, reset2, start2;
  logic [31:0] pc, pc2;
  logic [15:0] instruction, instruction2;
  logic        cpu_run, halted, cpu_run2, halted2;
  logic [8:0]  prog_len;
  logic [2:0]  prog_len2;
`ifdef IMEM_FETCH_CNT_EN
  logic [31:0] fetch_count, fetch_count2;
`endif

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic [15:0] model [256];
  int          model_len = 0;
  bit          running = 0;

  instr_fetch_server_if ld ();
  instr_fetch_server_if ld2 ();

  always #5 clk = ~clk;

  instr_fetch_server #(.AW(8)) dut (
    .clk(clk), .reset(reset), .ld(ld), .start(start), .pc(pc),
    .instruction(instruction), .cpu_run(cpu_run), .halted(halted), .prog_len(prog_len)
`ifdef IMEM_FETCH_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  instr_fetch_server #(.AW(2)) dut2 (
    .clk(clk), .reset(reset2), .ld(ld2), .start(start2), .pc(pc2),
    .instruction(instruction2), .cpu_run(cpu_run2), .halted(halted2), .prog_len(prog_len2)
`ifdef IMEM_FETCH_CNT_EN
    , .fetch_count(fetch_count2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_len = 0;
    running = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_word(input logic [15:0] d, input bit last);
    int n = 0;
    ld.load_valid = 1'b1;
    ld.load_data  = d;
    ld.load_last  = last;
    @(negedge clk);
    while (ld.load_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (ld.load_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL load_ready_timeout got=%b exp=1", ld.load_ready);
    end else begin
      model[model_len] = d;
      model_len++;
    end
    tick();
    ld.load_valid = 1'b0;
    ld.load_last  = 1'b0;
  endtask

  task automatic set_pc(input logic [31:0] p);
    pc = p;
    exp_q.push_back((running && p < 32'(model_len)) ? model[p[7:0]] : NOP);
  endtask

  task automatic test_reset();
    pc = 32'd0;
    do_reset();
    @(negedge clk);
    checks++; if (ld.load_ready !== 1'b0) begin failures++; $display("FAIL reset_load_ready got=%b exp=0", ld.load_ready); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL reset_cpu_run got=%b exp=0", cpu_run); end
    checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
    checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL reset_prog_len got=%0d exp=0", prog_len); end
    checks++; if (instruction !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instruction, NOP); end
    tick();
  endtask

  task automatic test_load_run();
    logic [15:0] e;
    // start and load_valid together in IDLE: only the state change
    ld.load_valid = 1'b1; ld.load_data = 16'hDEAD; ld.load_last = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; ld.load_valid = 1'b0; ld.load_last = 1'b0;
    @(negedge clk);
    checks++; if (ld.load_ready !== 1'b1) begin failures++; $display("FAIL idle_start_ready got=%b exp=1", ld.load_ready); end
    checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL idle_start_len got=%0d exp=0", prog_len); end
    tick();
    load_word(16'h1111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (ld.load_ready !== 1'b1) begin failures++; $display("FAIL stall_ready[%0d] got=%b exp=1", i, ld.load_ready); end
      checks++; if (prog_len !== 9'd1) begin failures++; $display("FAIL stall_len[%0d] got=%0d exp=1", i, prog_len); end
      tick();
    end
    load_word(16'h2222, 1'b0);
    load_word(16'h3333, 1'b1);
    @(negedge clk);
    checks++; if (ld.load_ready !== 1'b0) begin failures++; $display("FAIL ready_state_ready got=%b exp=0", ld.load_ready); end
    checks++; if (prog_len !== 9'd3) begin failures++; $display("FAIL loaded_len got=%0d exp=3", prog_len); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL ready_cpu_run got=%b exp=0", cpu_run); end
    tick();
    pc = 32'd0;
    pulse_start();
    running = 1;
    for (int i = 0; i < 3; i++) begin
      set_pc(32'(i));
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (instruction !== e) begin failures++; $display("FAIL fetch pc=%0d got=%h exp=%h", i, instruction, e); end
      checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL run_cpu_run pc=%0d got=%b exp=1", i, cpu_run); end
      tick();
    end
  endtask

  task automatic test_halt();
    logic [15:0] e;
    set_pc(32'd3);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (instruction !== e) begin failures++; $display("FAIL past_end_instr got=%h exp=%h", instruction, e); end
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL past_end_cpu_run got=%b exp=1", cpu_run); end
    tick();
    running = 0;
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL halt_cpu_run got=%b exp=0", cpu_run); end
`ifdef IMEM_FETCH_CNT_EN
    checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL fetch_count_halt got=%0d exp=3", fetch_count); end
`endif
    tick();
    set_pc(32'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (instruction !== e) begin failures++; $display("FAIL halt_pc0_instr got=%h exp=%h", instruction, e); end
    tick();
    tick();
`ifdef IMEM_FETCH_CNT_EN
    @(negedge clk);
    checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL fetch_count_hold got=%0d exp=3", fetch_count); end
    tick();
`endif
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] e;
    do_reset();
    pulse_start();
    load_word(16'h5555, 1'b0);
    load_word(16'h6666, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_len = 0;
    @(negedge clk);
    checks++; if (prog_len !== 9'd0) begin failures++; $display("FAIL midload_reset_len got=%0d exp=0", prog_len); end
    checks++; if (ld.load_ready !== 1'b0) begin failures++; $display("FAIL midload_reset_ready got=%b exp=0", ld.load_ready); end
    tick();
    pulse_start();
    load_word(16'hABCD, 1'b1);
    @(negedge clk);
    checks++; if (prog_len !== 9'd1) begin failures++; $display("FAIL reload_len got=%0d exp=1", prog_len); end
    tick();
    pc = 32'd0;
    pulse_start();
    running = 1;
    set_pc(32'd0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (instruction !== e) begin failures++; $display("FAIL reload_pc0 got=%h exp=%h", instruction, e); end
    tick();
    set_pc(32'h0000_0100);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++; if (instruction !== e) begin failures++; $display("FAIL no_alias got=%h exp=%h", instruction, e); end
    tick();
    running = 0;
    @(negedge clk);
    checks++; if (halted !== 1'b1) begin failures++; $display("FAIL no_alias_halt got=%b exp=1", halted); end
`ifdef IMEM_FETCH_CNT_EN
    checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL reload_fetch_count got=%0d exp=1", fetch_count); end
`endif
    tick();
  endtask

  task automatic test_reset_in_run();
    do_reset();
    pulse_start();
    load_word(16'h7777, 1'b1);
    pc = 32'd0;
    pulse_start();
    @(negedge clk);
    checks++; if (cpu_run !== 1'b1) begin failures++; $display("FAIL run_before_reset got=%b exp=1", cpu_run); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_len = 0;
    @(negedge clk);
    checks++; if (cpu_run !== 1'b0) begin failures++; $display("FAIL run_reset_cpu_run got=%b exp=0", cpu_run); end
    checks++; if (instruction !== NOP) begin failures++; $display("FAIL run_reset_instr got=%h exp=%h", instruction, NOP); end
    tick();
  endtask

  task automatic test_full_array();
    logic [15:0] e;
    reset2 = 1'b1;
    tick();
    tick();
    reset2 = 1'b0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld2.load_valid = 1'b1;
      ld2.load_data  = 16'hA000 + 16'(i);
      ld2.load_last  = 1'b0;
      @(negedge clk);
      checks++; if (ld2.load_ready !== 1'b1) begin failures++; $display("FAIL aw2_ready[%0d] got=%b exp=1", i, ld2.load_ready); end
      tick();
    end
    ld2.load_valid = 1'b0;
    @(negedge clk);
    checks++; if (prog_len2 !== 3'd4) begin failures++; $display("FAIL aw2_len got=%0d exp=4", prog_len2); end
    checks++; if (ld2.load_ready !== 1'b0) begin failures++; $display("FAIL aw2_ready_after got=%b exp=0", ld2.load_ready); end
    tick();
    pc2 = 32'd0;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pc2 = 32'(i);
      exp_q.push_back(i < 4 ? 16'hA000 + 16'(i) : NOP);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++; if (instruction2 !== e) begin failures++; $display("FAIL aw2_fetch pc=%0d got=%h exp=%h", i, instruction2, e); end
      tick();
    end
    @(negedge clk);
    checks++; if (halted2 !== 1'b1 || cpu_run2 !== 1'b0) begin failures++; $display("FAIL aw2_halt got=%b/%b exp=1/0", halted2, cpu_run2); end
`ifdef IMEM_FETCH_CNT_EN
    checks++; if (fetch_count2 !== 32'd4) begin failures++; $display("FAIL aw2_fetch_count got=%0d exp=4", fetch_count2); end
`endif
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pc = '0;
    reset2 = 1'b0; start2 = 1'b0; pc2 = '0;
    ld.load_valid = 1'b0; ld.load_data = '0; ld.load_last = 1'b0;
    ld2.load_valid = 1'b0; ld2.load_data = '0; ld2.load_last = 1'b0;
    test_reset();
    test_load_run();
    test_halt();
    test_reset_mid_load();
    test_reset_in_run();
    test_full_array();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
